// File: rtl/idli_sqi_ctrl.sv
// idli_sqi_ctrl: sequential SQI (quad-SPI) controller for the external serial SRAM.
// Turns a start request plus a 16b address into a read (0x03) or write (0x02)
// transaction, then streams 4b slices one per clock until the core asks to stop.
//
// Most bus outputs come from registers that are loaded with the next state's
// values. The exception is a write data cycle. There, the nibble offered by the
// core goes straight onto SIO and opens the SCK gate in the same cycle. This lets
// a slice be consumed and clocked into the memory in one cycle. A stop in that
// cycle then still completes the transfer before CS rises in END.

module idli_sqi_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,

    // Core-side transaction control
    input  logic        i_start,
    input  logic        i_wr,
    input  logic [15:0] i_addr,
    input  logic        i_stop,

    // Write slice stream (bus order)
    input  logic        i_wr_vld,
    input  logic [3:0]  i_wr_slice,
    output logic        o_wr_rdy,

    // Read slice stream (bus order)
    output logic        o_rd_vld,
    output logic [3:0]  o_rd_slice,

    output logic        o_busy,

    // SQI pins
    output logic        o_sqi_cs_n,
    output logic        o_sqi_sck_en,
    output logic [3:0]  o_sqi_sio,
    output logic        o_sqi_oe,
    input  logic [3:0]  i_sqi_sio
);

    typedef logic [3:0]  slice_t;
    typedef logic [15:0] data_t;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StData,
        StEnd
    } state_e;

    localparam logic [7:0] CmdRead  = 8'h03;
    localparam logic [7:0] CmdWrite = 8'h02;

    // Last index of each counted phase (CMD 2, ADDR 6, DUMMY 2 cycles)
    localparam logic [2:0] CmdLast   = 3'd1;
    localparam logic [2:0] AddrLast  = 3'd5;
    localparam logic [2:0] DummyLast = 3'd1;

    state_e     state_q;
    logic [2:0] cnt_q;
    logic       wr_q;
    data_t      addr_q;

    logic       cs_n_q;
    logic       sck_en_q;
    logic       oe_q;
    slice_t     sio_q;
    logic       rd_vld_q;
    slice_t     rd_slice_q;
    logic       wr_rdy_q;
    logic       busy_q;

    slice_t     addr_nib;
    logic       wr_xfer;

    // Next address nibble to drive, given the index of the nibble on the bus now.
    // The 24b address is 0x00 followed by the 16b address, MSB nibble first.
    always_comb begin
        addr_nib = 4'h0;
        case (cnt_q)
            3'd1:    addr_nib = addr_q[15:12];
            3'd2:    addr_nib = addr_q[11:8];
            3'd3:    addr_nib = addr_q[7:4];
            3'd4:    addr_nib = addr_q[3:0];
            default: addr_nib = 4'h0;
        endcase
    end

    // A write slice is consumed in any write data cycle where the core offers one.
    always_comb begin
        wr_xfer = (state_q == StData) && wr_q && i_wr_vld;
    end

    // Transaction FSM: sequences the phases and loads the registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            cs_n_q     <= 1'b1;
            sck_en_q   <= 1'b0;
            oe_q       <= 1'b0;
            sio_q      <= '0;
            rd_vld_q   <= 1'b0;
            rd_slice_q <= '0;
            wr_rdy_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // A read slice is valid for exactly one cycle after it is sampled
            rd_vld_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        state_q  <= StCmd;
                        cnt_q    <= 3'd0;
                        wr_q     <= i_wr;
                        addr_q   <= i_addr;
                        cs_n_q   <= 1'b0;
                        sck_en_q <= 1'b1;
                        oe_q     <= 1'b1;
                        busy_q   <= 1'b1;
                        sio_q    <= i_wr ? CmdWrite[7:4] : CmdRead[7:4];
                    end
                end

                StCmd: begin
                    if (cnt_q == CmdLast) begin
                        state_q <= StAddr;
                        cnt_q   <= 3'd0;
                        sio_q   <= 4'h0;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                        sio_q <= wr_q ? CmdWrite[3:0] : CmdRead[3:0];
                    end
                end

                StAddr: begin
                    if (cnt_q == AddrLast) begin
                        cnt_q <= 3'd0;
                        if (wr_q) begin
                            // Writes stall until the core offers a slice, so
                            // the gate stays shut and the last address nibble
                            // stays on the bus.
                            state_q  <= StData;
                            sck_en_q <= 1'b0;
                            wr_rdy_q <= 1'b1;
                        end else begin
                            state_q <= StDummy;
                            oe_q    <= 1'b0;
                            sio_q   <= 4'h0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                        sio_q <= addr_nib;
                    end
                end

                StDummy: begin
                    if (cnt_q == DummyLast) begin
                        state_q <= StData;
                        cnt_q   <= 3'd0;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end

                StData: begin
                    if (!wr_q) begin
                        rd_slice_q <= i_sqi_sio;
                        rd_vld_q   <= 1'b1;
                    end else if (i_wr_vld) begin
                        // Remember the nibble so a stall cycle keeps it on SIO
                        sio_q <= i_wr_slice;
                    end

                    if (i_stop) begin
                        state_q  <= StEnd;
                        cs_n_q   <= 1'b1;
                        sck_en_q <= 1'b0;
                        oe_q     <= 1'b0;
                        wr_rdy_q <= 1'b0;
                        sio_q    <= 4'h0;
                    end
                end

                StEnd: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Output assignments; only write data cycles bypass the SIO/SCK registers.
    always_comb begin
        o_sqi_cs_n   = cs_n_q;
        o_sqi_oe     = oe_q;
        o_sqi_sck_en = sck_en_q | wr_xfer;
        o_sqi_sio    = wr_xfer ? i_wr_slice : sio_q;
        o_rd_vld     = rd_vld_q;
        o_rd_slice   = rd_slice_q;
        o_wr_rdy     = wr_rdy_q;
        o_busy       = busy_q;
    end

endmodule

// File: tb/tb_idli_sqi_ctrl.sv
// Self-checking bench for idli_sqi_ctrl.
// A behavioural SQI SRAM (byte array plus bus decoder) serves reads and captures
// writes. Expected bus sequences come from the command/address word, and read
// data comes from the memory contents.

module tb_idli_sqi_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic        i_wr;
    logic [15:0] i_addr;
    logic        i_stop;
    logic        i_wr_vld;
    logic [3:0]  i_wr_slice;
    logic        o_wr_rdy;
    logic        o_rd_vld;
    logic [3:0]  o_rd_slice;
    logic        o_busy;
    logic        o_sqi_cs_n;
    logic        o_sqi_sck_en;
    logic [3:0]  o_sqi_sio;
    logic        o_sqi_oe;
    logic [3:0]  i_sqi_sio = 4'h0;

    int nchecks = 0;
    int nerrors = 0;

    logic [7:0]  mem [0:65535];

    // Memory model state: clocked-nibble count, header shift register, write nibbles
    int          m_cnt = 0;
    logic [31:0] m_hdr = '0;
    logic [3:0]  m_wq[$];

    idli_sqi_ctrl dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_wr         (i_wr),
        .i_addr       (i_addr),
        .i_stop       (i_stop),
        .i_wr_vld     (i_wr_vld),
        .i_wr_slice   (i_wr_slice),
        .o_wr_rdy     (o_wr_rdy),
        .o_rd_vld     (o_rd_vld),
        .o_rd_slice   (o_rd_slice),
        .o_busy       (o_busy),
        .o_sqi_cs_n   (o_sqi_cs_n),
        .o_sqi_sck_en (o_sqi_sck_en),
        .o_sqi_sio    (o_sqi_sio),
        .o_sqi_oe     (o_sqi_oe),
        .i_sqi_sio    (i_sqi_sio)
    );

    always #5 i_clk = ~i_clk;

    // SQI SRAM: decode each clocked nibble mid-cycle and drive read data for the edge
    always @(negedge i_clk) begin
        logic [15:0] a;
        logic [7:0]  b;
        int          d;
        i_sqi_sio = 4'($urandom);
        if (o_sqi_cs_n === 1'b0) begin
            if (o_sqi_sck_en === 1'b1) begin
                if (m_cnt < 8) begin
                    m_hdr = {m_hdr[27:0], o_sqi_sio};
                end else if (m_hdr[31:24] == 8'h02) begin
                    m_wq.push_back(o_sqi_sio);
                end else if (m_hdr[31:24] == 8'h03 && m_cnt >= 10) begin
                    d = m_cnt - 10;
                    a = m_hdr[15:0] + 16'(d / 2);
                    b = mem[a];
                    i_sqi_sio = (d % 2 == 0) ? b[7:4] : b[3:0];
                end
                m_cnt++;
            end
        end else if (m_cnt != 0) begin
            if (m_hdr[31:24] == 8'h02) begin
                for (int k = 0; k + 1 < m_wq.size(); k += 2) begin
                    a = m_hdr[15:0] + 16'(k / 2);
                    mem[a] = {m_wq[k], m_wq[k + 1]};
                end
            end
            m_wq.delete();
            m_cnt = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end, observed timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read transaction started in the current cycle (cycle 0); n data nibbles.
    // glitch_cyc pulses start/stop during the header; hold_start keeps i_start high.
    task automatic run_read(input logic [15:0] addr, input int n, input int glitch_cyc,
                            input bit hold_start);
        logic [3:0]  exp_rd[$];
        logic [31:0] hdr;
        logic [15:0] a;
        logic [7:0]  b;
        for (int j = 0; j < n; j++) begin
            a = addr + 16'(j / 2);
            b = mem[a];
            exp_rd.push_back((j % 2 == 0) ? b[7:4] : b[3:0]);
        end
        hdr = {8'h03, 8'h00, addr};
        i_start = 1'b1;
        i_wr    = 1'b0;
        i_addr  = addr;
        step();
        i_start = hold_start;
        for (int c = 1; c <= 10; c++) begin
            chk($sformatf("rd busy c%0d", c), o_busy, 1);
            chk($sformatf("rd cs_n c%0d", c), o_sqi_cs_n, 0);
            chk($sformatf("rd sck_en c%0d", c), o_sqi_sck_en, 1);
            chk($sformatf("rd rd_vld c%0d", c), o_rd_vld, 0);
            if (c <= 8) begin
                chk($sformatf("rd oe c%0d", c), o_sqi_oe, 1);
                chk($sformatf("rd hdr nibble c%0d", c), o_sqi_sio, (hdr >> (4 * (8 - c))) & 15);
            end else begin
                chk($sformatf("rd dummy oe c%0d", c), o_sqi_oe, 0);
            end
            if (c == glitch_cyc) begin
                i_start = 1'b1;
                i_stop  = 1'b1;
                i_wr    = 1'b1;
                i_addr  = 16'($urandom);
            end
            step();
            if (c == glitch_cyc) begin
                i_start = hold_start;
                i_stop  = 1'b0;
                i_wr    = 1'b0;
                i_addr  = addr;
            end
        end
        for (int c = 11; c <= 11 + n; c++) begin
            if (c <= 10 + n) begin
                chk($sformatf("rd data cs_n c%0d", c), o_sqi_cs_n, 0);
                chk($sformatf("rd data sck_en c%0d", c), o_sqi_sck_en, 1);
            end else begin
                chk($sformatf("rd end cs_n c%0d", c), o_sqi_cs_n, 1);
                chk($sformatf("rd end sck_en c%0d", c), o_sqi_sck_en, 0);
                chk($sformatf("rd end busy c%0d", c), o_busy, 1);
            end
            chk($sformatf("rd data oe c%0d", c), o_sqi_oe, 0);
            if (c == 11) begin
                chk("rd first vld", o_rd_vld, 0);
            end else begin
                chk($sformatf("rd vld c%0d", c), o_rd_vld, 1);
                chk($sformatf("rd slice c%0d", c), o_rd_slice, exp_rd[c - 12]);
            end
            if (c == 10 + n) i_stop = 1'b1;
            step();
            i_stop = 1'b0;
        end
        chk("rd idle busy", o_busy, 0);
        chk("rd idle cs_n", o_sqi_cs_n, 1);
        chk("rd idle vld", o_rd_vld, 0);
        chk("rd idle sck_en", o_sqi_sck_en, 0);
    endtask

    // Write transaction of the given bytes; gap2 stalls exactly the second data cycle,
    // otherwise stalls are random.
    task automatic run_write(input logic [15:0] addr, input logic [7:0] wb[$], input bit gap2);
        logic [3:0]  sl[$];
        logic [31:0] hdr;
        logic [3:0]  prev;
        logic [15:0] a;
        bit          vld;
        int          idx;
        int          c;
        foreach (wb[k]) begin
            sl.push_back(wb[k][7:4]);
            sl.push_back(wb[k][3:0]);
        end
        hdr = {8'h02, 8'h00, addr};
        i_start = 1'b1;
        i_wr    = 1'b1;
        i_addr  = addr;
        step();
        i_start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("wr cs_n c%0d", k), o_sqi_cs_n, 0);
            chk($sformatf("wr oe c%0d", k), o_sqi_oe, 1);
            chk($sformatf("wr sck_en c%0d", k), o_sqi_sck_en, 1);
            chk($sformatf("wr rdy c%0d", k), o_wr_rdy, 0);
            chk($sformatf("wr hdr nibble c%0d", k), o_sqi_sio, (hdr >> (4 * (8 - k))) & 15);
            step();
        end
        prev = addr[3:0];
        idx  = 0;
        c    = 9;
        while (idx < sl.size()) begin
            chk($sformatf("wr rdy c%0d", c), o_wr_rdy, 1);
            chk($sformatf("wr data cs_n c%0d", c), o_sqi_cs_n, 0);
            chk($sformatf("wr data oe c%0d", c), o_sqi_oe, 1);
            vld = (c > 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (gap2) vld = (c != 10);
            i_wr_vld   = vld;
            i_wr_slice = vld ? sl[idx] : 4'($urandom);
            i_stop     = vld && (idx == sl.size() - 1);
            #1;
            chk($sformatf("wr sck_en c%0d", c), o_sqi_sck_en, vld);
            chk($sformatf("wr sio c%0d", c), o_sqi_sio, vld ? sl[idx] : prev);
            if (vld) begin
                prev = sl[idx];
                idx++;
            end
            step();
            c++;
            i_wr_vld = 1'b0;
            i_stop   = 1'b0;
        end
        chk("wr end cs_n", o_sqi_cs_n, 1);
        chk("wr end sck_en", o_sqi_sck_en, 0);
        chk("wr end rdy", o_wr_rdy, 0);
        chk("wr end busy", o_busy, 1);
        step();
        chk("wr idle busy", o_busy, 0);
        foreach (wb[k]) begin
            a = addr + 16'(k);
            chk($sformatf("wr mem %0h", a), mem[a], wb[k]);
        end
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [15:0] ra;
        int          nb;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        i_rst      = 1'b1;
        i_start    = 1'b0;
        i_wr       = 1'b0;
        i_addr     = '0;
        i_stop     = 1'b0;
        i_wr_vld   = 1'b0;
        i_wr_slice = '0;
        repeat (3) step();
        chk("reset cs_n", o_sqi_cs_n, 1);
        chk("reset sck_en", o_sqi_sck_en, 0);
        chk("reset oe", o_sqi_oe, 0);
        chk("reset sio", o_sqi_sio, 0);
        chk("reset rd_vld", o_rd_vld, 0);
        chk("reset rd_slice", o_rd_slice, 0);
        chk("reset wr_rdy", o_wr_rdy, 0);
        chk("reset busy", o_busy, 0);
        i_rst = 1'b0;
        step();
        chk("idle busy", o_busy, 0);
        chk("idle cs_n", o_sqi_cs_n, 1);

        // Directed read of A,B,C,D at 0x1234, stop in cycle 14
        mem[16'h1234] = 8'hAB;
        mem[16'h1235] = 8'hCD;
        run_read(16'h1234, 4, 0, 1'b0);

        // Directed write 0x5678 at 0xBEEF with a stall in the second data cycle
        q = '{8'h56, 8'h78};
        run_write(16'hBEEF, q, 1'b1);

        // Start (with stop) pulsed during ADDR is ignored
        run_read(16'($urandom), 4, 5, 1'b0);

        // Reset asserted in DUMMY, then a fresh read
        i_start = 1'b1;
        i_wr    = 1'b0;
        i_addr  = 16'($urandom);
        step();
        i_start = 1'b0;
        repeat (8) step();
        chk("dummy oe", o_sqi_oe, 0);
        chk("dummy cs_n", o_sqi_cs_n, 0);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("abort cs_n", o_sqi_cs_n, 1);
        chk("abort oe", o_sqi_oe, 0);
        chk("abort busy", o_busy, 0);
        chk("abort sck_en", o_sqi_sck_en, 0);
        run_read(16'($urandom), 3, 0, 1'b0);

        // Back-to-back with start held high across the stop
        run_read(16'($urandom), 2, 0, 1'b1);
        run_read(16'($urandom), 3, 0, 1'b0);

        // Stop in the first data cycle: one rd_vld pulse
        run_read(16'($urandom), 1, 0, 1'b0);

        // Random write then read-back of the same region
        for (int t = 0; t < 8; t++) begin
            ra = 16'($urandom);
            nb = $urandom_range(1, 4);
            q.delete();
            for (int k = 0; k < nb; k++) q.push_back(8'($urandom));
            run_write(ra, q, 1'b0);
            run_read(ra, 2 * nb + $urandom_range(0, 3), 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
